nvram_upload_ctrl: RTL and testbench
====================================

Name: nvram_upload_ctrl

Overview:
- Core-side responder for the HPS ioctl upload path. It is the read-back counterpart of the ioctl download/DIP writers.
- Serves a block of core RAM (hiscore/NVRAM region) byte-by-byte to the HPS on `ioctl_din`.
- Requests uploads itself via `ioctl_upload_req` when the RAM is dirty and the OSD opens.
- Pauses the game CPU and takes the RAM port while the upload runs. Sits beside the hiscore/pause blocks in the emu top.

Parameters:
- AW, 12, RAM address width.
- DEPTH, 4096, number of bytes served; valid addresses are 0..DEPTH-1.
- RAM_LAT, 1, clock cycles from `ram_addr` change to valid `ram_data` (1..3).
- UPLOAD_INDEX, 8'd4, `ioctl_index` value this block answers.
- SETTLE_CYCLES, 24'd4_900_000, quiet time (about 100 ms at 49 MHz) after the last dirty write before a request is allowed.

Ports:
- clk_49m  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ioctl_upload  in  1  HPS upload in progress
- ioctl_index  in  8  upload target index
- ioctl_addr  in  25  byte address requested by HPS
- ioctl_rd  in  1  one-cycle read strobe for `ioctl_addr`
- ioctl_din  out  8  byte returned to HPS
- ioctl_upload_req  out  1  one-cycle pulse asking HPS to start an upload
- osd_open  in  1  OSD_STATUS level
- autosave  in  1  enables automatic requests
- ram_dirty_wr  in  1  pulse on any CPU write into the served region
- cpu_pause  out  1  pause request to the CPU/pause block
- cpu_paused  in  1  CPU halted acknowledge
- ram_access  out  1  block owns the RAM port (top muxes address)
- ram_addr  out  AW  RAM read address
- ram_data  in  8  RAM read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - dirty=0; settle counter=0.
- Dirty tracking:
  - `ram_dirty_wr` sets dirty and reloads the settle counter to SETTLE_CYCLES.
  - The counter decrements to 0 and holds there.
  - When `ram_dirty_wr` coincides with a completed upload, dirty stays set (the write wins).
- Request:
  - In IDLE, on a rising edge of `osd_open` with autosave=1, dirty=1 and settle counter=0, pulse `ioctl_upload_req` for exactly 1 cycle.
  - At most one pulse per `osd_open` rising edge.
- States: IDLE -> PAUSE -> SERVE -> FETCH -> SERVE ... -> RELEASE -> IDLE.
  - IDLE: on `ioctl_upload`=1 with `ioctl_index`==UPLOAD_INDEX, go to PAUSE and assert `cpu_pause`. Any other index is ignored.
  - PAUSE: wait for `cpu_paused`=1, then assert `ram_access` and go to SERVE. If `ioctl_upload` drops first, go to RELEASE.
  - SERVE: on `ioctl_rd`, latch `ioctl_addr`, drive `ram_addr` = addr[AW-1:0], go to FETCH.
    - A strobe arriving in PAUSE is held (one-deep) and served on entry to SERVE.
  - FETCH: wait RAM_LAT cycles, register `ram_data` into `ioctl_din`, return to SERVE.
    - Total latency from strobe to valid `ioctl_din` = RAM_LAT+1 cycles.
    - Strobes arriving during FETCH are queued one-deep; a second extra strobe overwrites the queued address.
  - Address >= DEPTH: `ioctl_din`=8'h00 with no RAM access; latency is still RAM_LAT+1.
  - Serving address DEPTH-1 marks the upload complete.
  - `ioctl_upload` falling edge in SERVE or FETCH: finish any in-flight fetch, then go to RELEASE.
  - RELEASE: deassert `ram_access` in the first cycle and `cpu_pause` in the next, then IDLE. If complete, clear dirty.
- `ioctl_din` holds its last value between reads.
- Reset mid-operation returns immediately to the reset values. This drops `cpu_pause` and `ram_access` asynchronously.

Optional Feature:
- Macro NVRAM_UPLOAD_CHECKSUM_EN.
  - Defined: address DEPTH returns the 8-bit two's-complement checksum of all served bytes 0..DEPTH-1. Completion is marked at address DEPTH instead of DEPTH-1. The accumulator clears on entry to PAUSE.
  - Undefined: address DEPTH returns 8'h00 like any out-of-range address; no accumulator logic exists.

Decomposition:
- Package nvram_upload_pkg holds:
  - the state enum (IDLE, PAUSE, SERVE, FETCH, RELEASE);
  - localparam widths for the settle counter (24) and the ioctl address (25).
- One sub-module: upload_settle_timer, holding the dirty flag plus the settle counter, with a ready output.
- FSM and datapath stay in nvram_upload_ctrl.

Test Plan:
- Basic upload: DEPTH=16, RAM byte i = 8'hA0+i. Upload index 4, strobe addresses 0..15 after pause ack.
  -> `ioctl_din` = A0..AF, each valid RAM_LAT+1 cycles after its strobe; `cpu_pause` high throughout; dirty cleared; `busy` low 2 cycles after `ioctl_upload` falls.
- Request gating: dirty write, then `osd_open` rising edge before settle expires -> no `ioctl_upload_req`. Repeat after settle -> exactly one 1-cycle pulse. With autosave=0 -> no pulse.
- Wrong index: upload with index 0 -> `cpu_pause`, `ram_access` and `ioctl_din` unchanged; state stays IDLE.
- Out of range and abort: read address 20 (DEPTH=16) -> 8'h00. Drop `ioctl_upload` after address 7 -> RELEASE; dirty remains 1.
- Edge events:
  - `ram_dirty_wr` in the same cycle as completion -> dirty stays 1.
  - Strobe during PAUSE -> served once `cpu_paused` arrives.
  - Reset asserted in FETCH -> all outputs 0 at once.
- NVRAM_UPLOAD_CHECKSUM_EN: bytes 0..15 = 8'h01 -> address 16 returns 8'hF0; dirty cleared only after address 16 is read.

Source files
------------

// File: rtl/nvram_upload_pkg.sv
// rtl/nvram_upload_pkg.sv - shared state type and widths for the NVRAM upload controller
package nvram_upload_pkg;

  localparam int SETTLE_W = 24;
  localparam int IOCTL_AW = 25;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAUSE   = 3'd1,
    SERVE   = 3'd2,
    FETCH   = 3'd3,
    RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/upload_settle_timer.sv
// rtl/upload_settle_timer.sv - dirty flag plus quiet-time counter gating upload requests
module upload_settle_timer
  import nvram_upload_pkg::*;
#(
  parameter logic [SETTLE_W-1:0] SETTLE_CYCLES = 24'd4_900_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_dirty_wr,
  input  logic i_clear,
  output logic o_dirty,
  output logic o_ready
);

  logic                r_dirty;
  logic [SETTLE_W-1:0] r_count;

  // A CPU write in the same cycle as the clear wins, so the region stays dirty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dirty <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_dirty_wr)   r_dirty <= 1'b1;
      else if (i_clear) r_dirty <= 1'b0;

      if (i_dirty_wr)          r_count <= SETTLE_CYCLES;
      else if (r_count != '0)  r_count <= r_count - 1'b1;
    end
  end

  assign o_dirty = r_dirty;
  assign o_ready = (r_count == '0);

endmodule

// File: rtl/nvram_upload_ctrl.sv
// rtl/nvram_upload_ctrl.sv - serves a core RAM region to the HPS over the ioctl upload path
// Optional NVRAM_UPLOAD_CHECKSUM_EN: address DEPTH returns the checksum of bytes 0..DEPTH-1.
module nvram_upload_ctrl
  import nvram_upload_pkg::*;
#(
  parameter int                  AW            = 12,
  parameter int                  DEPTH         = 4096,
  parameter int                  RAM_LAT       = 1,
  parameter logic [7:0]          UPLOAD_INDEX  = 8'd4,
  parameter logic [SETTLE_W-1:0] SETTLE_CYCLES = 24'd4_900_000
) (
  input  logic                clk_49m,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic                ioctl_rd,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_upload_req,
  input  logic                osd_open,
  input  logic                autosave,
  input  logic                ram_dirty_wr,
  output logic                cpu_pause,
  input  logic                cpu_paused,
  output logic                ram_access,
  output logic [AW-1:0]       ram_addr,
  input  logic [7:0]          ram_data,
  output logic                busy
);

  localparam logic [IOCTL_AW-1:0] DEPTH_A = IOCTL_AW'(DEPTH);
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  localparam logic [IOCTL_AW-1:0] LAST_ADDR = IOCTL_AW'(DEPTH);
`else
  localparam logic [IOCTL_AW-1:0] LAST_ADDR = IOCTL_AW'(DEPTH - 1);
`endif

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_osd_d;
  logic                r_upload_req;
  logic                r_cpu_pause;
  logic                r_ram_access;
  logic [AW-1:0]       r_ram_addr;
  logic [7:0]          r_din;
  logic                r_pend;
  logic [IOCTL_AW-1:0] r_pend_addr;
  logic [IOCTL_AW-1:0] r_fetch_addr;
  logic [1:0]          r_wait;
  logic                r_complete;
  logic                w_dirty;
  logic                w_ready;
  logic                w_clear;
  logic                w_start;
  logic                w_serve_go;
  logic                w_fetch_done;
  logic [IOCTL_AW-1:0] w_sel_addr;
  logic [7:0]          w_oor_byte;

  assign w_start      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign w_serve_go   = r_pend || ioctl_rd;
  assign w_sel_addr   = r_pend ? r_pend_addr : ioctl_addr;
  assign w_fetch_done = (r_wait == 2'(RAM_LAT));
  assign w_clear      = (r_state == RELEASE) && r_complete;

  upload_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .i_clk      (clk_49m),
    .i_rst_n    (reset),
    .i_dirty_wr (ram_dirty_wr),
    .i_clear    (w_clear),
    .o_dirty    (w_dirty),
    .o_ready    (w_ready)
  );

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nx = PAUSE;
      PAUSE:   if (!ioctl_upload) w_state_nx = RELEASE;
               else if (cpu_paused) w_state_nx = SERVE;
      SERVE:   if (!ioctl_upload) w_state_nx = RELEASE;
               else if (w_serve_go) w_state_nx = FETCH;
      FETCH:   if (w_fetch_done) w_state_nx = ioctl_upload ? SERVE : RELEASE;
      RELEASE: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Pause/access track the next state so ram_access drops one cycle before cpu_pause.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_osd_d      <= 1'b0;
      r_upload_req <= 1'b0;
      r_cpu_pause  <= 1'b0;
      r_ram_access <= 1'b0;
      r_ram_addr   <= '0;
      r_din        <= 8'h00;
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_fetch_addr <= '0;
      r_wait       <= 2'd0;
      r_complete   <= 1'b0;
    end else begin
      r_osd_d      <= osd_open;
      r_upload_req <= (r_state == IDLE) && osd_open && !r_osd_d && autosave && w_dirty && w_ready;
      r_cpu_pause  <= (w_state_nx != IDLE);
      r_ram_access <= (w_state_nx == SERVE) || (w_state_nx == FETCH);

      if (r_state == IDLE && w_start) r_complete <= 1'b0;

      if (r_state == SERVE && ioctl_upload && w_serve_go) begin
        r_fetch_addr <= w_sel_addr;
        r_wait       <= 2'd0;
        if (w_sel_addr < DEPTH_A) r_ram_addr <= w_sel_addr[AW-1:0];
        r_pend       <= r_pend && ioctl_rd;
        r_pend_addr  <= ioctl_addr;
      end else if ((r_state == PAUSE || r_state == FETCH) && ioctl_rd) begin
        r_pend      <= 1'b1;
        r_pend_addr <= ioctl_addr;
      end else if (r_state == IDLE || r_state == RELEASE) begin
        r_pend <= 1'b0;
      end

      if (r_state == FETCH) begin
        if (w_fetch_done) begin
          r_din <= (r_fetch_addr < DEPTH_A) ? ram_data : w_oor_byte;
          if (r_fetch_addr == LAST_ADDR) r_complete <= 1'b1;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
      end
    end
  end

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_csum <= 8'h00;
    end else if (r_state == IDLE && w_start) begin
      r_csum <= 8'h00;
    end else if (r_state == FETCH && w_fetch_done && r_fetch_addr < DEPTH_A) begin
      r_csum <= r_csum + ram_data;
    end
  end

  assign w_oor_byte = (r_fetch_addr == DEPTH_A) ? (8'h00 - r_csum) : 8'h00;
`else
  assign w_oor_byte = 8'h00;
`endif

  assign ioctl_din        = r_din;
  assign ioctl_upload_req = r_upload_req;
  assign cpu_pause        = r_cpu_pause;
  assign ram_access       = r_ram_access;
  assign ram_addr         = r_ram_addr;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// tb/tb_nvram_upload_ctrl.sv - directed self-checking bench for nvram_upload_ctrl
module tb_nvram_upload_ctrl;

  logic        clk_49m = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_upload_req;
  logic        osd_open;
  logic        autosave;
  logic        ram_dirty_wr;
  logic        cpu_pause;
  logic        cpu_paused;
  logic        ram_access;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        busy;

  logic [7:0]  mem [0:4095];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk_49m = ~clk_49m;

  always_ff @(posedge clk_49m) ram_data <= mem[ram_addr];

  nvram_upload_ctrl #(
    .AW(12), .DEPTH(16), .RAM_LAT(1), .UPLOAD_INDEX(8'd4), .SETTLE_CYCLES(24'd20)
  ) dut (
    .clk_49m          (clk_49m),
    .reset            (reset),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_addr       (ioctl_addr),
    .ioctl_rd         (ioctl_rd),
    .ioctl_din        (ioctl_din),
    .ioctl_upload_req (ioctl_upload_req),
    .osd_open         (osd_open),
    .autosave         (autosave),
    .ram_dirty_wr     (ram_dirty_wr),
    .cpu_pause        (cpu_pause),
    .cpu_paused       (cpu_paused),
    .ram_access       (ram_access),
    .ram_addr         (ram_addr),
    .ram_data         (ram_data),
    .busy             (busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_49m);
      #1;
    end
  endtask

  task automatic start_upload;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    tick(1);
    cpu_paused = 1'b1;
    tick(1);
  endtask

  task automatic stop_upload;
    ioctl_upload = 1'b0;
    tick(2);
    cpu_paused = 1'b0;
  endtask

  task automatic rd_byte(input int a, output logic [7:0] mid, output logic [7:0] fin);
    ioctl_addr = 25'(a);
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    tick(1);
    mid = ioctl_din;
    tick(1);
    fin = ioctl_din;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(2);
    checks++;
    if ({ioctl_din, ioctl_upload_req, cpu_pause, ram_access, ram_addr, busy} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got din=%h req=%b pause=%b acc=%b addr=%h busy=%b want all 0",
               ioctl_din, ioctl_upload_req, cpu_pause, ram_access, ram_addr, busy);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (dut.w_dirty !== 1'b0) begin
      failures++;
      $display("FAIL reset_dirty got %b want 0", dut.w_dirty);
    end
  endtask

  task automatic test_request_gating;
    int pulses;
    autosave     = 1'b1;
    ram_dirty_wr = 1'b1;
    tick(1);
    ram_dirty_wr = 1'b0;
    checks++;
    if (dut.w_dirty !== 1'b1) begin
      failures++;
      $display("FAIL dirty_set got %b want 1", dut.w_dirty);
    end
    osd_open = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (ioctl_upload_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL req_before_settle got %0d pulses want 0", pulses);
    end
    osd_open = 1'b0;
    tick(20);
    osd_open = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (ioctl_upload_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL req_after_settle got %0d pulse cycles want 1", pulses);
    end
    osd_open = 1'b0;
    autosave = 1'b0;
    tick(1);
    osd_open = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (ioctl_upload_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL req_autosave_off got %0d pulses want 0", pulses);
    end
    osd_open = 1'b0;
    tick(1);
  endtask

  task automatic test_wrong_index;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd0;
    tick(1);
    ioctl_addr = 25'd3;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    tick(3);
    checks++;
    if ({cpu_pause, ram_access, busy, ioctl_din} !== 11'd0) begin
      failures++;
      $display("FAIL wrong_index got pause=%b acc=%b busy=%b din=%h want 0 0 0 00",
               cpu_pause, ram_access, busy, ioctl_din);
    end
    ioctl_upload = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_upload;
    logic [7:0] mid, fin, prev;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    tick(1);
    checks++;
    if ({cpu_pause, busy, ram_access} !== 3'b110) begin
      failures++;
      $display("FAIL enter_pause got pause=%b busy=%b acc=%b want 1 1 0", cpu_pause, busy, ram_access);
    end
    tick(2);
    checks++;
    if (ram_access !== 1'b0) begin
      failures++;
      $display("FAIL wait_ack_access got %b want 0", ram_access);
    end
    cpu_paused = 1'b1;
    tick(1);
    checks++;
    if (ram_access !== 1'b1) begin
      failures++;
      $display("FAIL ack_access got %b want 1", ram_access);
    end
    prev = 8'h00;
    for (int i = 0; i < 16; i++) begin
      rd_byte(i, mid, fin);
      checks++;
      if (mid !== prev) begin
        failures++;
        $display("FAIL basic_latency addr=%0d got %h want held %h", i, mid, prev);
      end
      checks++;
      if (fin !== 8'(8'hA0 + i)) begin
        failures++;
        $display("FAIL basic_data addr=%0d got %h want %h", i, fin, 8'(8'hA0 + i));
      end
      checks++;
      if (cpu_pause !== 1'b1) begin
        failures++;
        $display("FAIL basic_pause addr=%0d got %b want 1", i, cpu_pause);
      end
      prev = fin;
    end
    ioctl_upload = 1'b0;
    tick(1);
    checks++;
    if ({ram_access, cpu_pause, busy} !== 3'b011) begin
      failures++;
      $display("FAIL release_first got acc=%b pause=%b busy=%b want 0 1 1", ram_access, cpu_pause, busy);
    end
    tick(1);
    checks++;
    if ({cpu_pause, busy, dut.w_dirty} !== 3'b000) begin
      failures++;
      $display("FAIL release_done got pause=%b busy=%b dirty=%b want 0 0 0", cpu_pause, busy, dut.w_dirty);
    end
    cpu_paused = 1'b0;
    tick(1);
  endtask

  task automatic test_out_of_range_abort;
    logic [7:0] mid, fin;
    ram_dirty_wr = 1'b1;
    tick(1);
    ram_dirty_wr = 1'b0;
    start_upload();
    rd_byte(5, mid, fin);
    checks++;
    if (fin !== 8'hA5) begin
      failures++;
      $display("FAIL oor_pre got %h want a5", fin);
    end
    rd_byte(20, mid, fin);
    checks++;
    if (mid !== 8'hA5 || fin !== 8'h00) begin
      failures++;
      $display("FAIL oor_data got mid=%h fin=%h want a5 00", mid, fin);
    end
    checks++;
    if (ram_addr !== 12'd5) begin
      failures++;
      $display("FAIL oor_no_ram got addr=%h want 005", ram_addr);
    end
    rd_byte(7, mid, fin);
    checks++;
    if (fin !== 8'hA7) begin
      failures++;
      $display("FAIL abort_last got %h want a7", fin);
    end
    stop_upload();
    checks++;
    if ({busy, dut.w_dirty} !== 2'b01) begin
      failures++;
      $display("FAIL abort_dirty got busy=%b dirty=%b want 0 1", busy, dut.w_dirty);
    end
  endtask

  task automatic test_pause_strobe_and_queue;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    tick(1);
    ioctl_addr = 25'd9;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    tick(1);
    checks++;
    if (ioctl_din !== 8'hA7 || ram_access !== 1'b0) begin
      failures++;
      $display("FAIL pause_hold got din=%h acc=%b want a7 0", ioctl_din, ram_access);
    end
    cpu_paused = 1'b1;
    tick(3);
    checks++;
    if (ioctl_din !== 8'hA7) begin
      failures++;
      $display("FAIL pause_strobe_early got %h want a7", ioctl_din);
    end
    tick(1);
    checks++;
    if (ioctl_din !== 8'hA9) begin
      failures++;
      $display("FAIL pause_strobe_served got %h want a9", ioctl_din);
    end
    ioctl_addr = 25'd2;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_addr = 25'd3;
    tick(1);
    ioctl_addr = 25'd4;
    tick(1);
    ioctl_rd = 1'b0;
    checks++;
    if (ioctl_din !== 8'hA2) begin
      failures++;
      $display("FAIL queue_first got %h want a2", ioctl_din);
    end
    tick(2);
    checks++;
    if (ioctl_din !== 8'hA2) begin
      failures++;
      $display("FAIL queue_hold got %h want a2", ioctl_din);
    end
    tick(1);
    checks++;
    if (ioctl_din !== 8'hA4) begin
      failures++;
      $display("FAIL queue_overwrite got %h want a4", ioctl_din);
    end
    stop_upload();
  endtask

  task automatic test_complete_dirty_coincide;
    logic [7:0] mid, fin;
    start_upload();
    rd_byte(15, mid, fin);
    checks++;
    if (fin !== 8'hAF) begin
      failures++;
      $display("FAIL last_addr got %h want af", fin);
    end
    ioctl_upload = 1'b0;
    tick(1);
    ram_dirty_wr = 1'b1;
    tick(1);
    ram_dirty_wr = 1'b0;
    checks++;
    if ({busy, dut.w_dirty} !== 2'b01) begin
      failures++;
      $display("FAIL write_wins got busy=%b dirty=%b want 0 1", busy, dut.w_dirty);
    end
    cpu_paused = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_in_fetch;
    start_upload();
    ioctl_addr = 25'd1;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({cpu_pause, ram_access, busy, ioctl_din, ram_addr, ioctl_upload_req, dut.w_dirty} !== 26'd0) begin
      failures++;
      $display("FAIL reset_in_fetch got pause=%b acc=%b busy=%b din=%h addr=%h dirty=%b want all 0",
               cpu_pause, ram_access, busy, ioctl_din, ram_addr, dut.w_dirty);
    end
    ioctl_upload = 1'b0;
    cpu_paused   = 1'b0;
    #2;
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_checksum;
    logic [7:0] mid, fin;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    for (int i = 0; i < 16; i++) mem[i] = 8'h01;
    ram_dirty_wr = 1'b1;
    tick(1);
    ram_dirty_wr = 1'b0;
    start_upload();
    for (int i = 0; i < 16; i++) begin
      rd_byte(i, mid, fin);
      checks++;
      if (fin !== 8'h01) begin
        failures++;
        $display("FAIL csum_byte addr=%0d got %h want 01", i, fin);
      end
    end
    stop_upload();
    checks++;
    if (dut.w_dirty !== 1'b1) begin
      failures++;
      $display("FAIL csum_not_complete got dirty=%b want 1", dut.w_dirty);
    end
    start_upload();
    for (int i = 0; i < 16; i++) rd_byte(i, mid, fin);
    rd_byte(16, mid, fin);
    checks++;
    if (fin !== 8'hF0) begin
      failures++;
      $display("FAIL csum_value got %h want f0", fin);
    end
    stop_upload();
    checks++;
    if (dut.w_dirty !== 1'b0) begin
      failures++;
      $display("FAIL csum_complete got dirty=%b want 0", dut.w_dirty);
    end
`else
    start_upload();
    rd_byte(3, mid, fin);
    rd_byte(16, mid, fin);
    checks++;
    if (mid !== 8'hA3 || fin !== 8'h00) begin
      failures++;
      $display("FAIL depth_addr got mid=%h fin=%h want a3 00", mid, fin);
    end
    stop_upload();
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(8'hA0 + i);
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_addr   = '0;
    ioctl_rd     = 1'b0;
    osd_open     = 1'b0;
    autosave     = 1'b0;
    ram_dirty_wr = 1'b0;
    cpu_paused   = 1'b0;
    reset        = 1'b0;
    #1;
    test_reset();
    test_request_gating();
    test_wrong_index();
    test_basic_upload();
    test_out_of_range_abort();
    test_pause_strobe_and_queue();
    test_complete_dirty_coincide();
    test_reset_in_fetch();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
